// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   In-order dual-issue scheduler for the two-instruction fetch window.
//   Each cycle it issues both instructions, only instruction0, or neither.
//   It reports the decision back to the fetch cache and registers the issued
//   instructions toward execute. A per-register scoreboard tracks result
//   latency. A shadow counter holds issue after control transfers.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   nothing_filled      fetch window empty
//   instruction0/1      oldest / next instruction in the window
//   freeze1             instruction0 has a data hazard; window holds
//   freeze2             branch shadow active; window holds
//   dependency_on_ins2  only instruction0 issues; window slides by 1
//   issue0_valid/instr  registered slot-0 issue
//   issue1_valid/instr  registered slot-1 issue
//
// Configuration macro
//   SCHED_FORWARD_EN    when defined, non-load writers do not mark their rd
//                       busy, because results are forwarded.
module dual_issue_scheduler #(
    parameter int LOAD_LATENCY = 3,
    parameter int ALU_LATENCY  = 1,
    parameter int BRANCH_STALL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nothing_filled,
    input  logic [31:0] instruction0,
    input  logic [31:0] instruction1,
    output logic        freeze1,
    output logic        freeze2,
    output logic        dependency_on_ins2,
    output logic        issue0_valid,
    output logic [31:0] issue0_instr,
    output logic        issue1_valid,
    output logic [31:0] issue1_instr
);

    localparam int CW = (LOAD_LATENCY > 0) ? $clog2(LOAD_LATENCY + 1) : 1;
    localparam int SW = (BRANCH_STALL > 0) ? $clog2(BRANCH_STALL + 1) : 1;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    typedef struct packed {
        logic       bubble;
        logic       use1;
        logic       use2;
        logic       wr;
        logic       load;
        logic       mem;
        logic       ctrl;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [6:0] op;
        op       = ins[6:0];
        d.bubble = (ins == '0);
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.rd     = ins[11:7];
        d.use1   = !d.bubble && !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
        d.use2   = !d.bubble && (op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH);
        d.wr     = !d.bubble && (d.rd != '0) &&
                   (op == OPC_OP || op == OPC_OP_IMM || op == OPC_LOAD || op == OPC_LUI ||
                    op == OPC_AUIPC || op == OPC_JAL || op == OPC_JALR);
        d.load   = (op == OPC_LOAD);
        d.mem    = (op == OPC_LOAD) || (op == OPC_STORE);
        d.ctrl   = (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
        return d;
    endfunction

    function automatic logic hazard(input dec_t d, input logic [31:0] busy_v);
        return !d.bubble && ((d.use1 && busy_v[d.rs1]) ||
                             (d.use2 && busy_v[d.rs2]) ||
                             (d.wr   && busy_v[d.rd]));
    endfunction

    // Whether an issued writer marks its rd busy in the scoreboard.
    function automatic logic sets_sb(input dec_t d);
`ifdef SCHED_FORWARD_EN
        return d.wr && d.load;
`else
        return d.wr;
`endif
    endfunction

    function automatic logic [CW-1:0] latency(input dec_t d);
        return d.load ? CW'(LOAD_LATENCY) : CW'(ALU_LATENCY);
    endfunction

    logic [CW-1:0] cnt [32];
    logic [SW-1:0] shadow;
    logic [31:0]   busy;
    dec_t          d0, d1;
    logic          haz0, pair_blocked, go0, go1;

    always_comb begin
        busy = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    assign d0   = decode(instruction0);
    assign d1   = decode(instruction1);
    assign haz0 = hazard(d0, busy);

    // instruction1 may only pair when it is independent of instruction0.
    assign pair_blocked = d1.bubble || hazard(d1, busy) || d0.ctrl || (d0.mem && d1.mem) ||
                          (d0.wr && ((d1.use1 && d1.rs1 == d0.rd) ||
                                     (d1.use2 && d1.rs2 == d0.rd) ||
                                     (d1.wr   && d1.rd  == d0.rd)));

    // A bubble in instruction0 issues nothing but lets the window slide past it.
    always_comb begin
        freeze1            = 1'b0;
        freeze2            = 1'b0;
        dependency_on_ins2 = 1'b0;
        go0                = 1'b0;
        go1                = 1'b0;
        if (!rst && !nothing_filled) begin
            if (shadow != '0) begin
                freeze2 = 1'b1;
            end else if (haz0) begin
                freeze1 = 1'b1;
            end else if (d0.bubble) begin
                dependency_on_ins2 = 1'b1;
            end else if (pair_blocked) begin
                dependency_on_ins2 = 1'b1;
                go0                = 1'b1;
            end else begin
                go0 = 1'b1;
                go1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
            shadow       <= '0;
            issue0_valid <= 1'b0;
            issue0_instr <= '0;
            issue1_valid <= 1'b0;
            issue1_instr <= '0;
        end else begin
            for (int unsigned r = 1; r < 32; r++) begin
                if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
            cnt[0] <= '0;
            // Issue-time loads come after the decrement so they take priority.
            if (go0 && sets_sb(d0)) begin
                cnt[d0.rd] <= latency(d0);
            end
            if (go1 && sets_sb(d1)) begin
                cnt[d1.rd] <= latency(d1);
            end

            if ((go0 && d0.ctrl) || (go1 && d1.ctrl)) begin
                shadow <= SW'(BRANCH_STALL);
            end else if (shadow != '0) begin
                shadow <= shadow - 1'b1;
            end

            issue0_valid <= go0;
            issue1_valid <= go1;
            if (go0) begin
                issue0_instr <= instruction0;
            end
            if (go1) begin
                issue1_instr <= instruction1;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;

    localparam int LL = 3;
    localparam int AL = 1;
    localparam int BS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        nf;
    logic [31:0] i0, i1;
    logic        freeze1, freeze2, dependency_on_ins2;
    logic        issue0_valid, issue1_valid;
    logic [31:0] issue0_instr, issue1_instr;

    dual_issue_scheduler #(
        .LOAD_LATENCY(LL),
        .ALU_LATENCY (AL),
        .BRANCH_STALL(BS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .nothing_filled    (nf),
        .instruction0      (i0),
        .instruction1      (i1),
        .freeze1           (freeze1),
        .freeze2           (freeze2),
        .dependency_on_ins2(dependency_on_ins2),
        .issue0_valid      (issue0_valid),
        .issue0_instr      (issue0_instr),
        .issue1_valid      (issue1_valid),
        .issue1_instr      (issue1_instr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v0;
        logic [31:0] n0;
        logic        v1;
        logic [31:0] n1;
    } exp_t;
    exp_t q[$];

    // Reference model: absolute cycle numbers at which each register frees up.
    longint      ready[32];
    longint      shadow_end;
    longint      cyc;
    logic [31:0] last0, last1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] opc(input logic [31:0] x);
        return x[6:0];
    endfunction
    function automatic bit uses1(input logic [31:0] x);
        return x != 0 && !(opc(x) inside {7'h37, 7'h17, 7'h6F});
    endfunction
    function automatic bit uses2(input logic [31:0] x);
        return x != 0 && (opc(x) inside {7'h33, 7'h23, 7'h63});
    endfunction
    function automatic bit wr(input logic [31:0] x);
        return x != 0 && x[11:7] != 0 &&
               (opc(x) inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67});
    endfunction
    function automatic bit ld(input logic [31:0] x);
        return opc(x) == 7'h03;
    endfunction
    function automatic bit mem(input logic [31:0] x);
        return opc(x) inside {7'h03, 7'h23};
    endfunction
    function automatic bit ctrl(input logic [31:0] x);
        return opc(x) inside {7'h63, 7'h6F, 7'h67};
    endfunction
    function automatic bit busy(input int r);
        return r != 0 && cyc < ready[r];
    endfunction
    function automatic bit haz(input logic [31:0] x);
        return x != 0 && ((uses1(x) && busy(int'(x[19:15]))) ||
                          (uses2(x) && busy(int'(x[24:20]))) ||
                          (wr(x) && busy(int'(x[11:7]))));
    endfunction

    task automatic retire(input logic [31:0] x);
        if (wr(x)) begin
            if (ld(x)) ready[x[11:7]] = cyc + 1 + LL;
`ifndef SCHED_FORWARD_EN
            else ready[x[11:7]] = cyc + 1 + AL;
`endif
        end
        if (ctrl(x)) shadow_end = cyc + 1 + BS;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        shadow_end = 0;
        last0 = '0;
        last1 = '0;
    endtask

    // One decision cycle: 0 none, 1 freeze1, 2 freeze2, 3 slot 0 only / slide, 4 both.
    task automatic step(input bit n, input logic [31:0] a, input logic [31:0] b, output int dec);
        bit   g0, g1, ef1, ef2, ed, rawp;
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        nf  = n;
        i0  = a;
        i1  = b;
        #1;
        g0 = 0; g1 = 0; ef1 = 0; ef2 = 0; ed = 0;
        rawp = wr(a) && ((uses1(b) && b[19:15] == a[11:7]) ||
                         (uses2(b) && b[24:20] == a[11:7]) ||
                         (wr(b) && b[11:7] == a[11:7]));
        if (!n) begin
            if (cyc < shadow_end) ef2 = 1;
            else if (haz(a)) ef1 = 1;
            else if (a == 0) ed = 1;
            else if (b == 0 || haz(b) || rawp || ctrl(a) || (mem(a) && mem(b))) begin
                ed = 1; g0 = 1;
            end else begin
                g0 = 1; g1 = 1;
            end
        end
        check("freeze1", 32'(freeze1), 32'(ef1));
        check("freeze2", 32'(freeze2), 32'(ef2));
        check("dependency_on_ins2", 32'(dependency_on_ins2), 32'(ed));
        if (g0) last0 = a;
        if (g1) last1 = b;
        e.v0 = g0; e.n0 = last0; e.v1 = g1; e.n1 = last1;
        q.push_back(e);
        if (g0) retire(a);
        if (g1) retire(b);
        dec = g1 ? 4 : ed ? 3 : ef2 ? 2 : ef1 ? 1 : 0;
        cyc++;
    endtask

    task automatic expect_flags(input string name, input bit f1, input bit f2, input bit d);
        check(name, {29'b0, freeze1, freeze2, dependency_on_ins2}, {29'b0, f1, f2, d});
    endtask

    task automatic drain();
        int d;
        repeat (4) step(1'b1, 32'h0, 32'h0, d);
    endtask

    function automatic logic [31:0] gen();
        logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [6:0] fn7;
        logic [2:0] fn3;
        if ($urandom_range(0, 15) == 0) return 32'h0;
        fn7 = 7'($urandom);
        fn3 = 3'($urandom);
        return {fn7, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), fn3,
                5'($urandom_range(0, 5)), ops[$urandom_range(0, 8)]};
    endfunction

    // Monitor: each registered issue is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("issue0_valid", 32'(issue0_valid), 32'(e.v0));
                check("issue0_instr", issue0_instr, e.n0);
                check("issue1_valid", 32'(issue1_valid), 32'(e.v1));
                check("issue1_instr", issue1_instr, e.n1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          d;
        int          pc;
        bit          n;
        logic [31:0] prog[$];
        exp_t        e;

        cyc = 0;
        model_reset();
        rst = 1'b1;
        nf  = 1'b0;
        i0  = 32'h003100B3;
        i1  = 32'h0;
        #1;
        check("reset_flags", {29'b0, freeze1, freeze2, dependency_on_ins2}, 32'h0);
        check("reset_issue0_valid", 32'(issue0_valid), 32'h0);
        check("reset_issue0_instr", issue0_instr, 32'h0);
        check("reset_issue1_valid", 32'(issue1_valid), 32'h0);
        check("reset_issue1_instr", issue1_instr, 32'h0);
        repeat (2) @(posedge clk);

        // Independent pair dual-issues.
        step(1'b0, 32'h00100413, 32'h003100B3, d);
        expect_flags("tp_dual", 0, 0, 0);
        drain();

        // Intra-pair RAW on x1, then the consumer across cycles.
        step(1'b0, 32'h003100B3, 32'h00508233, d);
        expect_flags("tp_raw_pair", 0, 0, 1);
        step(1'b0, 32'h00508233, 32'h0, d);
`ifdef SCHED_FORWARD_EN
        expect_flags("tp_raw_next", 0, 0, 1);
`else
        expect_flags("tp_raw_next", 1, 0, 0);
        step(1'b0, 32'h00508233, 32'h0, d);
        expect_flags("tp_raw_after", 0, 0, 1);
`endif
        drain();

        // Load-use: three freeze cycles, then issue.
        step(1'b0, 32'h00012303, 32'h000303B3, d);
        expect_flags("tp_load_pair", 0, 0, 1);
        for (int k = 0; k < LL; k++) begin
            step(1'b0, 32'h000303B3, 32'h0, d);
            expect_flags("tp_load_freeze", 1, 0, 0);
        end
        step(1'b0, 32'h000303B3, 32'h0, d);
        expect_flags("tp_load_issue", 0, 0, 1);
        drain();

        // Branch shadow.
        step(1'b0, 32'h00000063, 32'h003100B3, d);
        expect_flags("tp_branch", 0, 0, 1);
        for (int k = 0; k < BS; k++) begin
            step(1'b0, 32'h003100B3, 32'h0, d);
            expect_flags("tp_shadow", 0, 1, 0);
        end
        drain();

        // Empty window.
        step(1'b1, 32'h00012303, 32'h003100B3, d);
        expect_flags("tp_nothing_filled", 0, 0, 0);
        drain();

        // Reset during a load freeze clears it immediately.
        step(1'b0, 32'h00012303, 32'h000303B3, d);
        @(negedge clk);
        i0 = 32'h000303B3;
        i1 = 32'h0;
        #1;
        expect_flags("tp_rst_before", 1, 0, 0);
        rst = 1'b1;
        #1;
        expect_flags("tp_rst_during", 0, 0, 0);
        model_reset();
        e.v0 = 0; e.n0 = 0; e.v1 = 0; e.n1 = 0;
        q.push_back(e);
        cyc++;
        step(1'b0, 32'h000303B3, 32'h0, d);
        expect_flags("tp_rst_after", 0, 0, 1);
        drain();

        // Randomized program stream driven through a modelled fetch window.
        for (int k = 0; k < 500; k++) prog.push_back(gen());
        pc = 0;
        for (int k = 0; k < 800; k++) begin
            if (pc + 1 >= prog.size()) pc = 0;
            n = ($urandom_range(0, 7) == 0);
            step(n, prog[pc], prog[pc+1], d);
            if (d == 4) pc += 2;
            else if (d == 3) pc += 1;
        end

        drain();
        @(posedge clk);
        #3;
        check("queue_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
